// File: rtl/sub_mol_pkg.sv
// Shared constants and types for the add_mol / sub_mol pipeline pair.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sub_mol_pkg;

  // Offset applied by add_mol producers and removed by sub_mol_pipeline.
  localparam int unsigned MOL_DEFAULT   = 42;
  localparam int unsigned WIDTH_DEFAULT = 32;

  typedef logic [WIDTH_DEFAULT-1:0] word_t;

  // One pipeline slot: valid bit, result word and underflow (borrow) flag.
  typedef struct packed {
    logic  valid;
    word_t data;
    logic  uf;
  } stage_t;

endpackage

// File: rtl/sub_mol_pipeline_pipe_stage_reg.sv
// Valid/data pipeline register with a single advance enable.
// Latency: 1 cycle from d_* to q_* when en is high.
// Backpressure: holds q_* while en is low; data loads only when a valid item enters.
module pipe_stage_reg #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         d_vld,
  input  logic [W-1:0] d_dat,
  output logic         q_vld,
  output logic [W-1:0] q_dat
);

  // Valid follows the upstream slot on advance; data only refreshes when a real item moves in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_vld <= 1'b0;
      q_dat <= '0;
    end else if (en) begin
      q_vld <= d_vld;
      if (d_vld) begin
        q_dat <= d_dat;
      end
    end
  end

endmodule

// File: rtl/sub_mol_pipeline.sv
// Subtracts MOL from each operand (mod 2^WIDTH) and flags the borrow as underflow.
// Latency: 2 cycles from accept to out_valid, one transfer per cycle sustained.
// Backpressure: out_ready stalls stage 1; stage 0 still fills if empty, then in_ready drops.
module sub_mol_pipeline
  import sub_mol_pkg::*;
#(
  parameter int unsigned     WIDTH = WIDTH_DEFAULT,
  parameter longint unsigned MOL   = MOL_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             underflow
);

  // A MOL that does not fit in WIDTH bits would silently truncate; refuse to elaborate.
  if (WIDTH < 64) begin : g_mol_chk
    if (MOL >= (64'd1 << WIDTH)) begin : g_mol_err
      $error("sub_mol_pipeline: MOL must be below 2**WIDTH");
    end
  end

  localparam logic [WIDTH-1:0] MOL_W = WIDTH'(MOL);

  logic             p0_vld;
  logic [WIDTH-1:0] p0_dat;
  logic             p1_vld;
  logic [WIDTH:0]   p1_dat;   // {borrow, difference}
  logic [WIDTH:0]   diff;
  logic             adv0;
  logic             adv1;

  // Each stage moves when the slot ahead of it is empty or is itself moving.
  assign adv1     = !p1_vld || out_ready;
  assign adv0     = !p0_vld || adv1;
  assign in_ready = adv0;

  // Zero-extended subtraction: the extra top bit is the borrow, i.e. p0_dat < MOL.
  assign diff = {1'b0, p0_dat} - {1'b0, MOL_W};

  pipe_stage_reg #(.W(WIDTH)) u_p0 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (adv0),
    .d_vld (in_valid),
    .d_dat (x),
    .q_vld (p0_vld),
    .q_dat (p0_dat)
  );

  pipe_stage_reg #(.W(WIDTH + 1)) u_p1 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (adv1),
    .d_vld (p0_vld),
    .d_dat (diff),
    .q_vld (p1_vld),
    .q_dat (p1_dat)
  );

  assign out_valid = p1_vld;
  assign out       = p1_dat[WIDTH-1:0];
  assign underflow = p1_dat[WIDTH];

endmodule
